step_counter: RTL and testbench

- Parametrised registered up/down counter with programmable step, synchronous load and overflow/underflow reporting.
- Generalises the team's fixed 8-bit +1 ripple incrementer to any width and step size, adds a stored count, and can optionally saturate instead of wrapping.
- Used as the general-purpose counter and address generator in the datapath.
- Supplies a one-cycle wrap pulse for chaining counters.

---
 rtl/step_counter.sv | 63 ++++++
 tb/tb_step_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Registered up/down counter with programmable step, synchronous load and bound-crossing pulse.
// Optional run-time saturation is compiled in when COUNTER_SAT_EN is defined.
module step_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP_W = WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              up_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
`ifdef COUNTER_SAT_EN
  input  logic              sat_mode_i,
`endif
  output logic [WIDTH-1:0]  count_o,
  output logic              wrap_o,
  output logic              at_max_o,
  output logic              at_min_o
);

  logic [WIDTH-1:0] stepExt;
  logic [WIDTH:0]   sumUp;
  logic [WIDTH:0]   diffDown;
  logic             crossed;
  logic [WIDTH-1:0] nextVal;

  assign stepExt  = WIDTH'(step_i);
  assign sumUp    = {1'b0, count_o} + {1'b0, stepExt};
  assign diffDown = {1'b0, count_o} - {1'b0, stepExt};

  // The extra MSB is the carry when adding and the borrow when subtracting.
  always_comb begin
    crossed = up_i ? sumUp[WIDTH] : diffDown[WIDTH];
    nextVal = up_i ? sumUp[WIDTH-1:0] : diffDown[WIDTH-1:0];
`ifdef COUNTER_SAT_EN
    if (crossed && sat_mode_i) begin
      nextVal = up_i ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= RST_VAL;
      wrap_o  <= 1'b0;
    end else if (load_i) begin
      count_o <= load_val_i;
      wrap_o  <= 1'b0;
    end else if (en_i) begin
      count_o <= nextVal;
      wrap_o  <= crossed;
    end else begin
      wrap_o  <= 1'b0;
    end
  end

  assign at_max_o = &count_o;
  assign at_min_o = ~|count_o;

endmodule

// File: tb/tb_step_counter.sv
// Directed and randomized checks of step_counter (WIDTH=8) against an integer-arithmetic model.
module tb_step_counter;

`ifdef COUNTER_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic       up_i;
  logic [7:0] step_i;
  logic       load_i;
  logic [7:0] load_val_i;
  logic       sat_mode_i;
  logic [7:0] count_o;
  logic       wrap_o;
  logic       at_max_o;
  logic       at_min_o;

  int tests;
  int fails;
  int mCount;
  bit mWrap;

  step_counter #(.WIDTH(8), .STEP_W(8), .RST_VAL(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .up_i(up_i),
    .step_i(step_i),
    .load_i(load_i),
    .load_val_i(load_val_i),
`ifdef COUNTER_SAT_EN
    .sat_mode_i(sat_mode_i),
`endif
    .count_o(count_o),
    .wrap_o(wrap_o),
    .at_max_o(at_max_o),
    .at_min_o(at_min_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer result, then decide wrap/clamp from its range.
  task automatic model_step(input bit ld, input int lv, input bit en, input bit up,
                            input int st, input bit sat);
    int r;
    if (ld) begin
      mCount = lv;
      mWrap  = 1'b0;
    end else if (en) begin
      r = up ? mCount + st : mCount - st;
      if (r > 255 || r < 0) begin
        mWrap = 1'b1;
        if (sat && SAT_BUILD) mCount = (r > 255) ? 255 : 0;
        else mCount = (r + 256) % 256;
      end else begin
        mCount = r;
        mWrap  = 1'b0;
      end
    end else begin
      mWrap = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count_o), 32'(mCount));
    check({tag, ".wrap"}, 32'(wrap_o), 32'(mWrap));
    check({tag, ".at_max"}, 32'(at_max_o), 32'(mCount == 255));
    check({tag, ".at_min"}, 32'(at_min_o), 32'(mCount == 0));
  endtask

  task automatic do_step(input string tag, input bit ld, input logic [7:0] lv, input bit en,
                         input bit up, input logic [7:0] st, input bit sat);
    @(negedge clk);
    load_i     = ld;
    load_val_i = lv;
    en_i       = en;
    up_i       = up;
    step_i     = st;
    sat_mode_i = sat;
    @(posedge clk);
    #1;
    model_step(ld, int'(lv), en, up, int'(st), sat);
    check_model(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mCount = 0;
    mWrap = 1'b0;
    rst_n = 1'b0;
    en_i = 1'b0;
    up_i = 1'b0;
    step_i = '0;
    load_i = 1'b0;
    load_val_i = '0;
    sat_mode_i = 1'b0;

    // 1. reset then count
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", 32'(count_o), 32'h00);
    check("rst.at_min", 32'(at_min_o), 32'h1);
    check("rst.at_max", 32'(at_max_o), 32'h0);
    check("rst.wrap", 32'(wrap_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      do_step("cnt", 1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 1'b0);
      check("cnt.const", 32'(count_o), 32'(i));
    end

    // 2. up wrap
    do_step("upw.load", 1'b1, 8'hFE, 1'b0, 1'b1, 8'd0, 1'b0);
    do_step("upw", 1'b0, 8'h00, 1'b1, 1'b1, 8'd3, 1'b0);
    check("upw.const", 32'({wrap_o, count_o}), 32'h101);
    do_step("upw.idle", 1'b0, 8'h00, 1'b0, 1'b1, 8'd3, 1'b0);
    check("upw.idle.const", 32'(wrap_o), 32'h0);

    // 3. down to exact bound, then underflow
    do_step("dn.load", 1'b1, 8'h05, 1'b0, 1'b0, 8'd0, 1'b0);
    do_step("dn.exact", 1'b0, 8'h00, 1'b1, 1'b0, 8'd5, 1'b0);
    check("dn.exact.const", 32'({at_min_o, wrap_o, count_o}), 32'h200);
    do_step("dn.wrap", 1'b0, 8'h00, 1'b1, 1'b0, 8'd2, 1'b0);
    check("dn.wrap.const", 32'({wrap_o, count_o}), 32'h1FE);

`ifdef COUNTER_SAT_EN
    // 4. saturation
    do_step("sat.load", 1'b1, 8'hFC, 1'b0, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      do_step("sat.up", 1'b0, 8'h00, 1'b1, 1'b1, 8'd10, 1'b1);
      check("sat.up.const", 32'({at_max_o, wrap_o, count_o}), 32'h3FF);
    end
    do_step("sat.dn", 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b1);
    check("sat.dn.const", 32'(count_o), 32'hDF);
`endif

    // 5. priority and hold
    do_step("pri", 1'b1, 8'h80, 1'b1, 1'b1, 8'd7, 1'b0);
    check("pri.const", 32'(count_o), 32'h80);
    for (int i = 0; i < 2; i++) begin
      do_step("hold", 1'b0, 8'h00, 1'b0, 1'b1, 8'd7, 1'b0);
      check("hold.const", 32'(count_o), 32'h80);
    end
    do_step("zstep", 1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0);
    check("zstep.const", 32'({wrap_o, count_o}), 32'h080);

    // 6. async reset mid-count
    do_step("ar.load", 1'b1, 8'h40, 1'b0, 1'b1, 8'd1, 1'b0);
    do_step("ar.run", 1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    mCount = 0;
    mWrap = 1'b0;
    check("ar.count", 32'(count_o), 32'h00);
    check("ar.at_min", 32'(at_min_o), 32'h1);
    #1;
    rst_n = 1'b1;
    do_step("ar.resume", 1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 1'b0);
    check("ar.resume.const", 32'(count_o), 32'h01);

    // randomized phase
    for (int i = 0; i < 300; i++) begin
      do_step("rnd", ($urandom_range(0, 9) == 0), 8'($urandom),
              ($urandom_range(0, 4) != 0), 1'($urandom), 8'($urandom_range(0, 80)),
              1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
